// File: rtl/bat_fb_writer.sv
// Bat sprite framebuffer writer. Decodes toggle-strobed bat commands from the CPU clock
// domain and streams erase/draw/clear glyph writes over a valid/ready port.
module bat_fb_writer #(
  parameter int unsigned COLS       = 80,
  parameter int unsigned ROWS       = 30,
  parameter int unsigned BAT_LEN    = 8,
  parameter int unsigned BAT_ROW    = 28,
  parameter logic [7:0]  CHAR_BAT   = 8'hDB,
  parameter logic [7:0]  CHAR_BLANK = 8'h20
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  bat_ctl,
  output logic [11:0] fb_addr,
  output logic [7:0]  fb_data,
  output logic        fb_we,
  input  logic        fb_ready,
  output logic [6:0]  bat_x,
  output logic        busy,
  output logic        cmd_drop
);

  localparam logic [11:0] LastCell = 12'(COLS * ROWS - 1);
  localparam logic [11:0] LastBeat = 12'(BAT_LEN - 1);
  localparam logic [11:0] RowBase  = 12'(BAT_ROW * COLS);
  localparam logic [7:0]  MaxX     = 8'(COLS - BAT_LEN);
  localparam logic [6:0]  CentreX  = 7'((COLS - BAT_LEN) / 2);
  localparam logic [3:0]  OpClear  = 4'd6;

  // StRst holds outputs quiet for the cycle(s) rst is asserted.
  typedef enum logic [2:0] {StRst, StInitClr, StIdle, StErase, StDraw, StClr} state_e;

  state_e      state_q, state_d;
  logic [4:0]  sync1_q, sync2_q;
  logic        tog_q, cmd_stb_q;
  logic [3:0]  cmd_op_q;
  logic [11:0] cnt_q, cnt_d;
  logic [6:0]  bat_x_q, bat_x_d, old_x_q, old_x_d, new_x_q, new_x_d;
  logic        pend_vld_q, pend_vld_d;
  logic [3:0]  pend_op_q, pend_op_d;
  logic        drop_q, drop_d;
  logic        new_cmd, accept, exec_vld;
  logic [3:0]  exec_op;
  logic [6:0]  tgt;

  // Saturated move target computed in signed 8-bit space.
  function automatic logic [6:0] move_target(input logic [3:0] op, input logic [6:0] x);
    logic signed [7:0] t;
    t = signed'({1'b0, x});
    case (op)
      4'd1:    t = t - 8'sd1;
      4'd2:    t = t + 8'sd1;
      4'd3:    t = t - 8'sd4;
      4'd4:    t = t + 8'sd4;
      4'd5:    t = signed'({1'b0, CentreX});
      default: ;
    endcase
    if (t < 8'sd0) t = 8'sd0;
    else if (t > signed'(MaxX)) t = signed'(MaxX);
    return t[6:0];
  endfunction

  // Two-flop synchroniser plus toggle edge detect; history preloaded on reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q   <= bat_ctl;
      sync2_q   <= bat_ctl;
      tog_q     <= bat_ctl[4];
      cmd_stb_q <= 1'b0;
      cmd_op_q  <= 4'd0;
    end else begin
      sync1_q   <= bat_ctl;
      sync2_q   <= sync1_q;
      tog_q     <= sync2_q[4];
      cmd_stb_q <= sync2_q[4] ^ tog_q;
      cmd_op_q  <= sync2_q[3:0];
    end
  end

  // FSM, counter, position and pending-command state registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StRst;
      cnt_q      <= 12'd0;
      bat_x_q    <= CentreX;
      old_x_q    <= 7'd0;
      new_x_q    <= 7'd0;
      pend_vld_q <= 1'b0;
      pend_op_q  <= 4'd0;
      drop_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      bat_x_q    <= bat_x_d;
      old_x_q    <= old_x_d;
      new_x_q    <= new_x_d;
      pend_vld_q <= pend_vld_d;
      pend_op_q  <= pend_op_d;
      drop_q     <= drop_d;
    end
  end

  // Next-state, command dispatch and write-port outputs.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    bat_x_d    = bat_x_q;
    old_x_d    = old_x_q;
    new_x_d    = new_x_q;
    pend_vld_d = pend_vld_q;
    pend_op_d  = pend_op_q;
    drop_d     = 1'b0;
    fb_we      = 1'b0;
    fb_addr    = 12'd0;
    fb_data    = CHAR_BLANK;
    exec_vld   = 1'b0;
    exec_op    = 4'd0;
    tgt        = bat_x_q;
    // Only opcodes 1..6 do anything; everything else is silently ignored.
    new_cmd    = cmd_stb_q && (cmd_op_q >= 4'd1) && (cmd_op_q <= 4'd6);
    accept     = 1'b0;

    if (state_q != StIdle && new_cmd) begin
      if (pend_vld_q) begin
        drop_d = 1'b1;
      end else begin
        pend_vld_d = 1'b1;
        pend_op_d  = cmd_op_q;
      end
    end

    case (state_q)
      StRst: state_d = StInitClr;
      StInitClr, StClr: begin
        fb_we   = 1'b1;
        fb_addr = cnt_q;
        accept  = fb_ready;
        if (accept) begin
          if (cnt_q == LastCell) begin
            cnt_d   = 12'd0;
            state_d = StDraw;
          end else begin
            cnt_d = cnt_q + 12'd1;
          end
        end
      end
      StErase: begin
        fb_we   = 1'b1;
        fb_addr = RowBase + 12'(old_x_q) + cnt_q;
        accept  = fb_ready;
        if (accept) begin
          if (cnt_q == LastBeat) begin
            cnt_d   = 12'd0;
            bat_x_d = new_x_q;
            state_d = StDraw;
          end else begin
            cnt_d = cnt_q + 12'd1;
          end
        end
      end
      StDraw: begin
        fb_we   = 1'b1;
        fb_addr = RowBase + 12'(bat_x_q) + cnt_q;
        fb_data = CHAR_BAT;
        accept  = fb_ready;
        if (accept) begin
          if (cnt_q == LastBeat) begin
            cnt_d   = 12'd0;
            state_d = StIdle;
          end else begin
            cnt_d = cnt_q + 12'd1;
          end
        end
      end
      StIdle: begin
        // A pending command wins; a toggle landing the same cycle refills the slot.
        if (pend_vld_q) begin
          exec_vld   = 1'b1;
          exec_op    = pend_op_q;
          pend_vld_d = new_cmd;
          pend_op_d  = cmd_op_q;
        end else if (new_cmd) begin
          exec_vld = 1'b1;
          exec_op  = cmd_op_q;
        end
        if (exec_vld) begin
          if (exec_op == OpClear) begin
            state_d = StClr;
          end else begin
            tgt = move_target(exec_op, bat_x_q);
            if (tgt != bat_x_q) begin
              old_x_d = bat_x_q;
              new_x_d = tgt;
              state_d = StErase;
            end
          end
        end
      end
      default: state_d = StRst;
    endcase
  end

  assign bat_x    = bat_x_q;
  assign busy     = (state_q != StIdle);
  assign cmd_drop = drop_q;

endmodule

// File: tb/tb_bat_fb_writer.sv
// Directed self-checking bench for bat_fb_writer.
module tb_bat_fb_writer;

  localparam logic [7:0] BLANK = 8'h20;
  localparam logic [7:0] BAT   = 8'hDB;

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  bat_ctl;
  logic [11:0] fb_addr;
  logic [7:0]  fb_data;
  logic        fb_we;
  logic        fb_ready;
  logic [6:0]  bat_x;
  logic        busy;
  logic        cmd_drop;

  int   n_assert = 0;
  int   n_fail   = 0;
  logic tog      = 1'b0;
  int   x_model  = 36;

  always #5 clk = ~clk;

  bat_fb_writer u_dut (
    .clk      (clk),
    .rst      (rst),
    .bat_ctl  (bat_ctl),
    .fb_addr  (fb_addr),
    .fb_data  (fb_data),
    .fb_we    (fb_we),
    .fb_ready (fb_ready),
    .bat_x    (bat_x),
    .busy     (busy),
    .cmd_drop (cmd_drop)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Called at a negedge; consumes n accepted beats, checking address order and data.
  task automatic seq_check(input int start, input int n, input logic [7:0] data,
                           input string tag);
    int          i = 0;
    int          bad = 0;
    int          waitc = 0;
    logic [11:0] exp_a;
    logic [11:0] bad_a = 12'd0;
    logic [7:0]  bad_d = 8'd0;
    int          bad_i = 0;
    while (i < n && waitc < 200) begin
      if (fb_we === 1'b1 && fb_ready === 1'b1) begin
        exp_a = 12'(start + i);
        if (fb_addr !== exp_a || fb_data !== data) begin
          if (bad == 0) begin
            bad_a = fb_addr;
            bad_d = fb_data;
            bad_i = i;
          end
          bad++;
        end
        i++;
        waitc = 0;
      end else begin
        waitc++;
      end
      @(negedge clk);
    end
    n_assert++;
    assert (bad == 0 && i == n) else begin
      n_fail++;
      $error("FAIL %s: beats %0d bad %0d (beat %0d got addr %0d data %h) required %0d beats addr %0d.. data %h",
             tag, i, bad, bad_i, bad_a, bad_d, n, start, data);
    end
  endtask

  task automatic send(input logic [3:0] op);
    tog     = ~tog;
    bat_ctl = {tog, op};
  endtask

  task automatic quiet_check(input string tag, input int cycles);
    int noisy = 0;
    repeat (cycles) begin
      @(negedge clk);
      if (fb_we !== 1'b0 || busy !== 1'b0 || cmd_drop !== 1'b0) noisy++;
    end
    check(tag, noisy, 0);
  endtask

  // Issues one command and checks the resulting erase/draw (or absence of writes).
  task automatic do_move(input logic [3:0] op);
    int nx = x_model;
    case (op)
      4'd1:    nx = x_model - 1;
      4'd2:    nx = x_model + 1;
      4'd3:    nx = x_model - 4;
      4'd4:    nx = x_model + 4;
      4'd5:    nx = 36;
      default: ;
    endcase
    if (nx < 0) nx = 0;
    if (nx > 72) nx = 72;
    send(op);
    if (nx != x_model) begin
      seq_check(2240 + x_model, 8, BLANK, "move_erase");
      seq_check(2240 + nx, 8, BAT, "move_draw");
    end else begin
      quiet_check("no_write", 12);
    end
    x_model = nx;
    check("move_bat_x", bat_x, nx);
    check("move_busy", busy, 0);
  endtask

  initial begin
    int lat;
    int drops;
    int held_bad;
    rst      = 1'b1;
    fb_ready = 1'b1;
    bat_ctl  = 5'd0;
    @(negedge clk);
    @(negedge clk);
    check("rst_fb_we", fb_we, 0);
    check("rst_busy", busy, 1);
    check("rst_fb_addr", fb_addr, 0);
    check("rst_fb_data", fb_data, 32'h20);
    check("rst_bat_x", bat_x, 36);
    check("rst_cmd_drop", cmd_drop, 0);
    rst = 1'b0;
    seq_check(0, 2400, BLANK, "init_clr");
    seq_check(2276, 8, BAT, "init_draw");
    check("init_busy", busy, 0);
    check("init_bat_x", bat_x, 36);

    // Right 1 with latency measurement
    send(4'd2);
    lat = 0;
    while (fb_we !== 1'b1 && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    check("latency", lat, 4);
    seq_check(2276, 8, BLANK, "r1_erase");
    seq_check(2277, 8, BAT, "r1_draw");
    x_model = 37;
    check("r1_bat_x", bat_x, 37);
    check("r1_busy", busy, 0);

    // Right saturation, then an extra right 4 that must do nothing
    repeat (10) do_move(4'd4);
    check("sat_right", bat_x, 72);
    do_move(4'd4);
    do_move(4'd9);
    do_move(4'd5);
    do_move(4'd1);
    // Left saturation down to column 0
    repeat (10) do_move(4'd3);
    check("sat_left", bat_x, 0);
    do_move(4'd1);

    // Backpressure during DRAW
    send(4'd2);
    seq_check(2240, 8, BLANK, "bp_erase");
    seq_check(2241, 3, BAT, "bp_draw_head");
    fb_ready = 1'b0;
    held_bad = 0;
    repeat (5) begin
      @(negedge clk);
      if (fb_we !== 1'b1 || fb_addr !== 12'd2244 || fb_data !== BAT) held_bad++;
    end
    check("bp_hold", held_bad, 0);
    fb_ready = 1'b1;
    seq_check(2244, 5, BAT, "bp_draw_tail");
    x_model = 1;
    check("bp_bat_x", bat_x, 1);

    // Clear with queued and dropped commands
    send(4'd6);
    drops = 0;
    fork
      begin
        seq_check(0, 2400, BLANK, "clr");
        seq_check(2241, 8, BAT, "clr_draw");
      end
      begin
        repeat (20) @(negedge clk);
        send(4'd2);
        repeat (10) begin
          @(negedge clk);
          if (cmd_drop === 1'b1) drops++;
        end
        send(4'd2);
        repeat (12) begin
          @(negedge clk);
          if (cmd_drop === 1'b1) drops++;
        end
      end
    join
    check("drop_pulses", drops, 1);
    fork
      begin
        seq_check(2241, 8, BLANK, "q_erase");
        seq_check(2242, 8, BAT, "q_draw");
        seq_check(2242, 8, BLANK, "t3_erase");
        seq_check(2246, 8, BAT, "t3_draw");
      end
      begin
        repeat (3) @(negedge clk);
        send(4'd4);
      end
    join
    x_model = 6;
    check("t3_bat_x", bat_x, 6);
    check("t3_busy", busy, 0);

    // Reset in the middle of DRAW
    send(4'd2);
    seq_check(2246, 8, BLANK, "rm_erase");
    seq_check(2247, 3, BAT, "rm_draw");
    rst = 1'b1;
    @(negedge clk);
    check("rm_fb_we", fb_we, 0);
    check("rm_bat_x", bat_x, 36);
    check("rm_busy", busy, 1);
    rst = 1'b0;
    seq_check(0, 2400, BLANK, "re_init_clr");
    seq_check(2276, 8, BAT, "re_init_draw");
    x_model = 36;
    check("re_busy", busy, 0);
    quiet_check("re_quiet", 10);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/bat_fb_writer.md
Name: bat_fb_writer

Overview:
- Consumes the 5-bit bat_ctl command word written by mips_cpu.
- Writes the bat (paddle) sprite into the character framebuffer that vga_char reads, through a write port with a valid/ready handshake.
- Maintains the bat position, erases the old glyphs and draws the new ones.
- Performs the screen clear after reset and on command.

Parameters:
- COLS, 80, characters per text row.
- ROWS, 30, text rows.
- BAT_LEN, 8, bat width in characters.
- BAT_ROW, 28, text row holding the bat.
- CHAR_BAT, 8'hDB, glyph code drawn for the bat.
- CHAR_BLANK, 8'h20, glyph code used for erase and clear.

Ports:
- clk  in  1  system clock, the same clock that drives vga_char.
- rst  in  1  reset; one clock, synchronous, active-high.
- bat_ctl  in  5  [4] toggle strobe, [3:0] opcode; produced in the CPU's divided clock domain.
- fb_addr  out  12  framebuffer cell address, row*COLS+col.
- fb_data  out  8  glyph code to write.
- fb_we  out  1  write valid.
- fb_ready  in  1  write accepted when fb_we and fb_ready are both high.
- bat_x  out  7  current bat left column.
- busy  out  1  high whenever the FSM is not in IDLE.
- cmd_drop  out  1  one-cycle pulse when a command is discarded.

Behaviour:
- Input synchronisation:
  - bat_ctl passes through a 2-flop synchroniser.
  - A command is captured when synced bit [4] differs from its previous synced value (toggle handshake).
  - Opcode is sampled from the same synced word.
- Opcodes:
  - 0 NOP.
  - 1 left 1.
  - 2 right 1.
  - 3 left 4.
  - 4 right 4.
  - 5 centre.
  - 6 clear screen.
  - 7-15 ignored: treated as NOP, no drop pulse.
- Position arithmetic:
  - Target is computed in 8-bit signed space and saturated to 0..COLS-BAT_LEN (72).
  - Centre = (COLS-BAT_LEN)/2 = 36.
- FSM states: INIT_CLR, IDLE, ERASE, DRAW, CLR.
  - INIT_CLR / CLR: write CHAR_BLANK to addresses 0..COLS*ROWS-1 in ascending order, then go to DRAW at current bat_x.
  - IDLE + move opcode:
    - If saturated target equals bat_x: no writes, stay IDLE.
    - Otherwise latch old_x and new_x, then go to ERASE.
  - ERASE: write CHAR_BLANK to BAT_ROW*COLS+old_x .. +BAT_LEN-1; then update bat_x to new_x and go to DRAW.
  - DRAW: write CHAR_BAT to BAT_ROW*COLS+bat_x .. +BAT_LEN-1; then go to IDLE.
  - IDLE + opcode 6: go to CLR.
- Write handshake:
  - Each cell is one beat.
  - fb_addr, fb_data and fb_we are held stable until accepted.
  - The counter advances only on accept.
  - No beat is skipped or duplicated.
- Latency:
  - Toggle at bat_ctl[4] is seen in the synced domain after 2 clk.
  - Command is decoded on the next edge.
  - First fb_we rises on the following cycle if IDLE, i.e. 4 clk after the input toggle when fb_ready is high.
  - Full move takes 2*BAT_LEN accepted beats.
- Pending command (while busy):
  - A command arriving while busy is stored in a 1-deep pending register.
  - It executes on return to IDLE, taking priority over new toggles that cycle.
  - A further command arriving while pending is full is discarded and cmd_drop pulses.
  - A NOP captured while busy is not stored and does not pulse.
- Reset values:
  - fb_we=0, fb_addr=0, fb_data=CHAR_BLANK, bat_x=36, busy=1, cmd_drop=0.
  - Pending register is empty.
  - Synchroniser history is set to the current input, so no spurious command fires.
  - FSM enters INIT_CLR on the first cycle after rst deasserts.
- Reset mid-operation: any in-flight beat is abandoned, fb_we is low the cycle after rst is sampled high, and the sequence restarts from INIT_CLR.
- Simultaneous events: a toggle arriving in the same cycle the FSM returns to IDLE with an empty pending register is executed directly, not queued.

Test Plan:
- Reset, fb_ready=1:
  - Exactly 2400 CHAR_BLANK writes to addresses 0..2399.
  - Then 8 writes of 8'hDB to 2276..2283.
  - busy falls; bat_x=36.
- Toggle with opcode 2 after init:
  - Blanks written to 2276..2283, then 8'hDB to 2277..2284.
  - bat_x=37; first fb_we 4 cycles after the toggle.
- Saturation:
  - Ten opcode-4 toggles, each issued after busy falls, end with bat_x=72 and the last draw at 2312..2319.
  - An eleventh opcode-4 causes no fb_we and busy stays 0.
- Backpressure:
  - During DRAW, hold fb_ready low 5 cycles.
  - fb_addr and fb_data stay constant, fb_we stays 1.
  - All 8 cells are still written once, in order.
- Overflow during CLR:
  - Three move toggles: first queued, second dropped with a single cmd_drop pulse.
  - Queued command executes after CLR+DRAW.
  - The third toggle arrives after the pending register clears and executes.
- Reset mid-DRAW:
  - Assert rst for one cycle after 3 beats.
  - fb_we is 0 next cycle, bat_x=36, and a full INIT_CLR sequence restarts at address 0.
